// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared encodings and widths for the 8-way round-robin mux arbiter.
package mux8_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/data bundle between the eight requesters and the arbiter.
interface mux8_rr_arbiter_if;
  import mux8_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [SELW-1:0] sel;
  logic            dout;
  logic            dout_valid;

  modport master (output req, din, input gnt, gnt_valid, sel, dout, dout_valid);
  modport slave  (input req, din, output gnt, gnt_valid, sel, dout, dout_valid);
endinterface

// File: rtl/mux8x1.sv
// Single-bit 8:1 mux.
module mux8x1 (
  input  logic [7:0] i_d,
  input  logic [2:0] i_sel,
  output logic       o_y
);
  assign o_y = i_d[i_sel];
endmodule

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: first set request at or after ptr, wrapping 7->0.
module rr_prio_enc8
  import mux8_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic            o_any,
  output logic [SELW-1:0] o_idx
);
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [SELW-1:0]   w_k;

  // Rotate so index ptr lands at bit 0, then the lowest set bit is the winner.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_k = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_k = SELW'(i);
    end
  end

  assign o_any = |i_req;
  assign o_idx = i_ptr + w_k;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the 8:1 mux select, with a hold limit per tenure
// and a registered copy of the muxed bit.
module mux8_rr_arbiter
  import mux8_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  mux8_rr_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t          r_state;
  logic [SELW-1:0] r_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic [NREQ-1:0] r_gnt;
  logic            r_gnt_valid;
  logic [SELW-1:0] r_sel;
  logic            r_dout;
  logic            r_dout_valid;

  logic            w_any;
  logic [SELW-1:0] w_idx;
  logic            w_mux;

  rr_prio_enc8 u_enc (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  mux8x1 u_mux (
    .i_d   (bus.din),
    .i_sel (r_sel),
    .o_y   (w_mux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_hold_cnt   <= '0;
      r_gnt        <= '0;
      r_gnt_valid  <= 1'b0;
      r_sel        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout       <= r_gnt_valid ? w_mux : 1'b0;
      r_dout_valid <= r_gnt_valid;

      // Any new grant (including self re-grant) reloads hold_cnt and ptr.
      if ((r_state == ST_IDLE && w_any) ||
          (r_state == ST_GRANT && !bus.req[r_sel] && w_any) ||
          (r_state == ST_GRANT && bus.req[r_sel] && r_hold_cnt >= HW'(MAX_HOLD))) begin
        r_state     <= ST_GRANT;
        r_sel       <= w_idx;
        r_gnt       <= NREQ'(1) << w_idx;
        r_gnt_valid <= 1'b1;
        r_hold_cnt  <= HW'(1);
        r_ptr       <= w_idx + SELW'(1);
      end else if (r_state == ST_GRANT && bus.req[r_sel]) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end else if (r_state == ST_GRANT) begin
        // Released with nobody waiting; sel keeps its last value.
        r_state     <= ST_IDLE;
        r_gnt       <= '0;
        r_gnt_valid <= 1'b0;
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.sel        = r_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer that shares an 8:1 single-bit mux datapath between eight requesters. It arbitrates level-sensitive requests, drives the 3-bit mux select and a one-hot grant, and bounds each tenure with a programmable hold limit. It registers the muxed bit for downstream logic. It sits directly in front of the 8x1 mux and owns its select input.

## Interface
- MAX_HOLD, 4: maximum consecutive grant cycles for one requester while another requester is pending. Legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  level request; bit n means requester n wants the mux.
- din  input  8  data bits; din[n] belongs to requester n.
- gnt  output 8  one-hot grant, or all zeros when idle.
- gnt_valid  output 1  high when any grant is active.
- sel  output 3  mux select; equals the index of the set gnt bit.
- dout  output 1  registered muxed bit, din[sel] from the previous cycle.
- dout_valid  output 1  dout holds a granted requester's bit.

## Operation
- State: IDLE, GRANT. Rotating pointer ptr[2:0]. Hold counter hold_cnt, width clog2(MAX_HOLD+1).
- Winner rule, the same in both states: scan req starting at index ptr, ascending, wrapping 7->0. The first set bit wins.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: go to GRANT. sel = winner, gnt = 1<<winner, hold_cnt = 1, ptr = winner+1 (mod 8).
- GRANT, where the current holder is h = sel:
  - req[h]==0 (release), other requests present: regrant to the winner back-to-back, with no idle cycle.
  - req[h]==0 (release), req==0: go to IDLE. gnt = 0. sel holds its last value.
  - req[h]==1 and hold_cnt < MAX_HOLD: keep the grant; hold_cnt++.
  - req[h]==1 and hold_cnt == MAX_HOLD: re-arbitrate with the winner rule. Because ptr = h+1, h is scanned last.
    - If another requester is pending, it wins.
    - If h is alone, h is re-granted.
    - In both cases hold_cnt = 1 and ptr = winner+1.
- Every new grant loads hold_cnt = 1 and ptr = winner+1, including a re-grant to the same requester.
- dout pipeline:
  - Each edge: dout <= gnt_valid ? din[sel] : 0, and dout_valid <= gnt_valid.
  - Values are taken from the pre-edge sel and gnt_valid.
- Invariants:
  - gnt is always zero or one-hot.
  - When gnt_valid is high, gnt == 1<<sel.
  - gnt_valid == (state==GRANT).

## Timing
- Reset values (on the rst edge): state IDLE, ptr 0, hold_cnt 0, gnt 0, gnt_valid 0, sel 0, dout 0, dout_valid 0.
- Reset asserted mid-tenure:
  - The grant drops on the same edge.
  - Arbitration restarts from ptr 0 on the first edge after rst deasserts.
- Grant latency: req sampled at edge k gives gnt visible after edge k, i.e. one cycle.
- Release latency: req[h] falling at edge k drops or switches gnt after edge k.
- Data latency: dout is one cycle behind sel.
- Maximum wait for a continuously requesting input: 7*MAX_HOLD cycles after the pending request is first sampled.
- A request that drops before being sampled is never granted. No request memory is kept.

## Structure
- Shared package `mux8_pkg`:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
  - constant NREQ=8;
  - constant SELW=3.
- Sub-module `rr_prio_enc8`, combinational:
  - inputs: req[7:0], ptr[2:0];
  - outputs: any, idx[2:0];
  - implements the rotate, find-first-set and unrotate search.
- The top level holds the FSM, ptr, hold_cnt, the grant and select registers, and the dout register.
- The mux itself is an instance of the team's 8x1 mux, driven by sel.

## Test plan
- Reset and single request:
  - rst high for 2 cycles, then req=8'h04, din=8'hFF.
  - Next cycle: gnt=8'h04, sel=2, gnt_valid=1.
  - One cycle later: dout=1, dout_valid=1.
- Round-robin rotation, MAX_HOLD=1, req=8'hFF held for 10 cycles:
  - sel sequence 0,1,2,…,7,0,1.
  - gnt stays one-hot every cycle.
- Hold limit, MAX_HOLD=4:
  - req=8'h01 is granted; req[5] rises 1 cycle later.
  - sel=0 for exactly 4 cycles, then sel=5.
  - Requester 0 stays at req=1 and regains sel=0 after requester 5 has held for 4 cycles.
- Lone holder past the limit, MAX_HOLD=2, req=8'h08 for 7 cycles:
  - gnt=8'h08 continuously, with no gap.
  - hold_cnt cycles 1,2,1,2,…
- Release handoff:
  - Holder 3 drops req while req[6]=1: gnt goes 8'h08 -> 8'h40 on the same edge, with no idle cycle.
  - All requests drop: gnt=0 and dout_valid=0 one cycle later.
- Reset mid-tenure:
  - With gnt=8'h20, pulse rst for 1 cycle while req=8'hA0 is held.
  - The grant clears on the rst edge.
  - On the next edge gnt=8'h20 (scan from ptr 0 finds bit 5 first).
